// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, big-endian byte image into
// instruction memory one 32-bit word per write, and holds the CPU in
// reset until the whole image has landed.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned MAX_WORDS   = 1024,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [7:0]             byte_in,
   input  logic                   byte_valid,
   output logic                   byte_ready,
   output logic                   mem_we,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_data,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic                   cpu_hold,
   output logic [COUNT_WIDTH-1:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_LOAD,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             idx_q;      // byte position within header/word
   logic [7:0]             hdr_msb_q;  // first header byte
   logic [COUNT_WIDTH-1:0] count_q;    // words promised by the header
   logic [COUNT_WIDTH-1:0] words_q;    // words already written
   logic [23:0]            shift_q;    // earlier bytes of the word in flight
   logic [31:0]            data_q;     // word presented to memory
   logic [31:0]            addr_q;
   logic                   we_q;

   logic        accept;
   logic        restart;
   logic        last_wr;
   logic [15:0] hdr_word;

   assign accept   = byte_valid && byte_ready;
   assign restart  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
   assign hdr_word = {hdr_msb_q, byte_in};
   // The write of the final word closes the load; no byte may be taken then.
   assign last_wr  = (state_q == S_LOAD) && we_q && ((words_q + COUNT_WIDTH'(1)) == count_q);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and status outputs
   always_comb begin
      state_d    = state_q;
      byte_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_hold   = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_HEADER;
         end
         S_HEADER: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (accept && idx_q[0]) begin
               if (hdr_word == 16'd0)                   state_d = S_DONE;
               else if ({16'd0, hdr_word} > MAX_WORDS)  state_d = S_ERROR;
               else                                     state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            busy       = 1'b1;
            byte_ready = !last_wr;
            if (last_wr) state_d = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_d = S_HEADER;
         end
         S_ERROR: begin
            error = 1'b1;
            if (start) state_d = S_HEADER;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Header capture, word assembly and write/address bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q     <= 2'd0;
         hdr_msb_q <= 8'd0;
         count_q   <= '0;
         words_q   <= '0;
         shift_q   <= 24'd0;
         data_q    <= 32'd0;
         addr_q    <= BASE_ADDR;
         we_q      <= 1'b0;
      end else begin
         we_q <= 1'b0;
         if (restart) begin
            idx_q   <= 2'd0;
            words_q <= '0;
            addr_q  <= BASE_ADDR;
         end
         if (state_q == S_HEADER && accept) begin
            if (!idx_q[0]) begin
               hdr_msb_q <= byte_in;
               idx_q     <= 2'd1;
            end else begin
               count_q <= COUNT_WIDTH'(hdr_word);
               idx_q   <= 2'd0;
            end
         end
         if (state_q == S_LOAD) begin
            // Retire the word written this cycle.
            if (we_q) begin
               addr_q  <= addr_q + 32'd4;
               words_q <= words_q + COUNT_WIDTH'(1);
            end
            // data_q is loaded only on a word's 4th byte, so a byte taken
            // during a write cycle starts the next word without disturbing it.
            if (accept) begin
               shift_q <= {shift_q[15:0], byte_in};
               if (idx_q == 2'd3) begin
                  data_q <= {shift_q, byte_in};
                  we_q   <= 1'b1;
                  idx_q  <= 2'd0;
               end else begin
                  idx_q <= idx_q + 2'd1;
               end
            end
         end
      end
   end

   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_data     = data_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0x0 and base 0x100) driven in
// lock-step; writes are captured and compared against a word-list model.
module tb_imem_loader;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0000_0100;
   localparam int          MAXW  = 1024;

   logic        clk = 1'b0;
   logic        reset, start, byte_valid;
   logic [7:0]  byte_in;
   logic        rdy0, we0, busy0, done0, err0, hold0;
   logic        rdy1, we1, busy1, done1, err1, hold1;
   logic [31:0] addr0, data0, addr1, data1;
   logic [15:0] wl0, wl1;

   always #5 clk = ~clk;

   imem_loader #(.BASE_ADDR(BASE0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(rdy0), .mem_we(we0),
      .mem_addr(addr0), .mem_data(data0), .busy(busy0), .done(done0),
      .error(err0), .cpu_hold(hold0), .words_loaded(wl0));

   imem_loader #(.BASE_ADDR(BASE1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(rdy1), .mem_we(we1),
      .mem_addr(addr1), .mem_data(data1), .busy(busy1), .done(done1),
      .error(err1), .cpu_hold(hold1), .words_loaded(wl1));

   int total = 0;
   int bad   = 0;

   logic [63:0] q0[$];
   logic [63:0] q1[$];

   // Capture every write strobe, away from the active edge.
   always @(negedge clk) begin
      if (we0) q0.push_back({addr0, data0});
      if (we1) q1.push_back({addr1, data1});
   end

   typedef struct packed {
      logic [15:0]      hdr;
      logic [7:0]       nsend;
      logic [7:0]       gap;
      logic [3:0][31:0] w;
      logic             ex_done;
      logic             ex_err;
      logic [15:0]      ex_wl;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one byte after `gap` idle cycles; return just after the edge
   // that accepted it.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
      logic r;
      int   n;
      byte_valid = 1'b0;
      repeat (gap) step();
      byte_in    = b;
      byte_valid = 1'b1;
      start      = st;
      r = 1'b0;
      n = 0;
      while (!r && n < 20) begin
         @(negedge clk);
         r = rdy0;
         step();
         n++;
      end
      start      = 1'b0;
      byte_valid = 1'b0;
      if (!r) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // One complete load; expected writes come from the header rule:
   // N==0 or N>MAX gives none, otherwise words w[0..N-1] at base+4*i.
   task automatic run_load(input string name, input logic [15:0] hdr,
                           input logic [7:0][31:0] w, input int nsend,
                           input int gap, input bit st_pulse,
                           input bit ex_done, input bit ex_err,
                           input logic [15:0] ex_wl);
      int  exp_n;
      int  g;
      q0.delete();
      q1.delete();
      exp_n = (hdr == 16'd0 || int'(hdr) > MAXW) ? 0 : int'(hdr);
      start = 1'b1;
      step();
      start = 1'b0;
      chk({name, "_busy"}, {31'd0, busy0}, 32'd1);
      chk({name, "_hold_start"}, {31'd0, hold0}, 32'd1);
      chk({name, "_wl_clear"}, {16'd0, wl0}, 32'd0);
      send_byte(hdr[15:8], gap < 0 ? int'($urandom_range(0, 2)) : gap, 1'b0);
      send_byte(hdr[7:0],  gap < 0 ? int'($urandom_range(0, 2)) : gap, 1'b0);
      for (int i = 0; i < nsend; i++) begin
         for (int b = 0; b < 4; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            send_byte(w[i][31-8*b -: 8], g, st_pulse && (b == 2));
         end
      end
      if (nsend > 0) begin
         chk({name, "_last_we"}, {31'd0, we0}, 32'd1);
         chk({name, "_last_rdy"}, {31'd0, rdy0}, 32'd0);
         step();
      end
      chk({name, "_done"},  {31'd0, done0}, {31'd0, ex_done});
      chk({name, "_err"},   {31'd0, err0},  {31'd0, ex_err});
      chk({name, "_hold"},  {31'd0, hold0}, {31'd0, !ex_done});
      chk({name, "_rdy"},   {31'd0, rdy0},  32'd0);
      chk({name, "_wl"},    {16'd0, wl0},   {16'd0, ex_wl});
      chk({name, "_wl1"},   {16'd0, wl1},   {16'd0, ex_wl});
      chk({name, "_done1"}, {31'd0, done1}, {31'd0, ex_done});
      repeat (2) step();
      chk({name, "_nwr0"}, q0.size(), exp_n);
      chk({name, "_nwr1"}, q1.size(), exp_n);
      for (int i = 0; i < exp_n && i < q0.size() && i < q1.size(); i++) begin
         chk({name, "_a0"}, q0[i][63:32], BASE0 + 32'(4 * i));
         chk({name, "_d0"}, q0[i][31:0],  w[i]);
         chk({name, "_a1"}, q1[i][63:32], BASE1 + 32'(4 * i));
         chk({name, "_d1"}, q1[i][31:0],  w[i]);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] hdr, input int nsend, input int gap,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input bit d, input bit e, input logic [15:0] wl);
      vec_t v;
      v.hdr = hdr; v.nsend = 8'(nsend); v.gap = 8'(gap);
      v.w = '0; v.w[0] = w0; v.w[1] = w1;
      v.ex_done = d; v.ex_err = e; v.ex_wl = wl;
      return v;
   endfunction

   initial begin
      logic [7:0][31:0] w;
      int n;

      vecs[0] = mk(16'd2,      2, 0, 32'h2008_0005, 32'h0109_5020, 1, 0, 16'd2);
      vecs[1] = mk(16'd2,      2, 3, 32'h2008_0005, 32'h0109_5020, 1, 0, 16'd2);
      vecs[2] = mk(16'd0,      0, 0, 32'h0,         32'h0,         1, 0, 16'd0);
      vecs[3] = mk(16'h0401,   0, 0, 32'h0,         32'h0,         0, 1, 16'd0);
      vecs[4] = mk(16'd1,      1, 0, 32'hDEAD_BEEF, 32'h0,         1, 0, 16'd1);

      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      repeat (3) step();
      chk("rst_rdy",  {31'd0, rdy0},  32'd0);
      chk("rst_we",   {31'd0, we0},   32'd0);
      chk("rst_addr0", addr0, BASE0);
      chk("rst_addr1", addr1, BASE1);
      chk("rst_data", data0, 32'd0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_err",  {31'd0, err0},  32'd0);
      chk("rst_hold", {31'd0, hold0}, 32'd1);
      chk("rst_wl",   {16'd0, wl0},   32'd0);
      reset = 1'b0;

      // Valid bytes in IDLE are ignored.
      byte_in = 8'h55; byte_valid = 1'b1;
      repeat (3) step();
      byte_valid = 1'b0;
      chk("idle_busy", {31'd0, busy0}, 32'd0);
      chk("idle_rdy",  {31'd0, rdy0},  32'd0);

      // Table of directed loads.
      for (int i = 0; i < 5; i++) begin
         w = '0;
         w[0] = vecs[i].w[0];
         w[1] = vecs[i].w[1];
         run_load($sformatf("vec%0d", i), vecs[i].hdr, w, int'(vecs[i].nsend),
                  int'(vecs[i].gap), 1'b0, vecs[i].ex_done, vecs[i].ex_err, vecs[i].ex_wl);
         if (vecs[i].ex_err) begin
            q0.delete();
            byte_in = 8'hAA; byte_valid = 1'b1;
            repeat (3) step();
            byte_valid = 1'b0;
            chk("err_stays", {31'd0, err0}, 32'd1);
            chk("err_nowr", q0.size(), 0);
         end
      end

      // After DONE a start pulse raises cpu_hold at the next edge.
      chk("pre_done", {31'd0, done0}, 32'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_hold", {31'd0, hold0}, 32'd1);
      chk("restart_done", {31'd0, done0}, 32'd0);

      // Reset in the middle of a 3-word load after 6 bytes.
      reset = 1'b1; step(); reset = 1'b0;
      q0.delete();
      start = 1'b1; step(); start = 1'b0;
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h03, 0, 1'b0);
      for (int b = 0; b < 6; b++) send_byte(8'(8'h10 + b), 0, 1'b0);
      chk("mid_wr", q0.size(), 1);
      chk("mid_wl", {16'd0, wl0}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_hold", {31'd0, hold0}, 32'd1);
      chk("mid_rst_wl",   {16'd0, wl0},   32'd0);
      chk("mid_rst_we",   {31'd0, we0},   32'd0);
      chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
      chk("mid_rst_addr", addr1, BASE1);
      w = '0; w[0] = 32'hCAFE_F00D;
      run_load("fresh", 16'd1, w, 1, 0, 1'b0, 1'b1, 1'b0, 16'd1);

      // Three words with start pulses mid-LOAD (base 0x100 checked on dut1).
      w = '0; w[0] = 32'h1111_2222; w[1] = 32'h3333_4444; w[2] = 32'h5555_6666;
      run_load("n3_start", 16'd3, w, 3, 0, 1'b1, 1'b1, 1'b0, 16'd3);

      // Randomized loads with random gaps.
      for (int t = 0; t < 8; t++) begin
         n = int'($urandom_range(1, 8));
         for (int i = 0; i < 8; i++) w[i] = $urandom;
         run_load($sformatf("rnd%0d", t), 16'(n), w, n, -1, t[0], 1'b1, 1'b0, 16'(n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global guard against a hung run.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

endmodule
